// File: rtl/alt_mem_ddrx_ecc_pkg.sv
// Shared constants for the DDRx SECDED write-path encoder: injection modes and
// Hamming parity-mask tables for the (39,32) and (72,64) codes.
package alt_mem_ddrx_ecc_pkg;

    localparam logic [1:0] INJ_NONE = 2'b00;
    localparam logic [1:0] INJ_SBE  = 2'b01;
    localparam logic [1:0] INJ_DBE  = 2'b10;
    localparam logic [1:0] INJ_CODE = 2'b11;

    // Row i selects the data bits covered by Hamming parity bit i.
    typedef logic [6:0][63:0] pmask_t;

    // Data bit d sits at the d-th non-power-of-two codeword position (3,5,6,7,9,...);
    // parity bit i covers every position whose index has bit i set.
    function automatic pmask_t gen_pmask(input int w);
        pmask_t m;
        int     pos;
        m   = '0;
        pos = 1;
        for (int d = 0; d < w; d++) begin
            pos++;
            while ((pos & (pos - 1)) == 0) pos++;
            for (int i = 0; i < 7; i++) begin
                if (pos[i]) m[i][d] = 1'b1;
            end
        end
        return m;
    endfunction

    localparam pmask_t PMASK32 = gen_pmask(32);
    localparam pmask_t PMASK64 = gen_pmask(64);

endpackage

// File: rtl/alt_mem_ddrx_ecc_encoder_core.sv
// Combinational SECDED check-bit generator. code = {overall parity, hamming parity},
// zero-extended to 8 bits for the 32-bit code.
module alt_mem_ddrx_ecc_encoder_core
    import alt_mem_ddrx_ecc_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] data,
    output logic [7:0]   code
);

    localparam int     NP   = (W == 64) ? 7 : 6;
    localparam pmask_t MASK = (W == 64) ? PMASK64 : PMASK32;

    logic [NP-1:0] hp;

    always_comb begin
        hp = '0;
        for (int i = 0; i < NP; i++) begin
            hp[i] = ^(data & MASK[i][W-1:0]);
        end
    end

    assign code = 8'({^{data, hp}, hp});

endmodule

// File: rtl/alt_mem_ddrx_ecc_encoder_pipe.sv
// Two-stage valid/ready SECDED write encoder with per-beat ECC enable, RMW flagging
// and beat-targeted error injection.
module alt_mem_ddrx_ecc_encoder_pipe
    import alt_mem_ddrx_ecc_pkg::*;
#(
    parameter int CFG_DATA_WIDTH     = 40,
    parameter int CFG_ECC_CODE_WIDTH = 8,
    parameter int CFG_INJ_CNT_WIDTH  = 8
) (
    input  logic                           ctl_clk,
    input  logic                           ctl_reset,
    input  logic                           cfg_enable_ecc,
    input  logic [1:0]                     cfg_inject_mode,
    input  logic [CFG_INJ_CNT_WIDTH-1:0]   cfg_inject_beat,
    input  logic                           inject_arm,
    output logic                           inject_done,
    input  logic [CFG_DATA_WIDTH-1:0]      input_data,
    input  logic [CFG_DATA_WIDTH/8-1:0]    input_be,
    input  logic                           input_valid,
    output logic                           input_ready,
    output logic [CFG_DATA_WIDTH-1:0]      output_data,
    output logic [CFG_DATA_WIDTH/8-1:0]    output_be,
    output logic                           output_partial,
    output logic                           output_valid,
    input  logic                           output_ready
);

    localparam int DW     = CFG_DATA_WIDTH;
    localparam int W      = CFG_DATA_WIDTH - CFG_ECC_CODE_WIDTH;
    localparam int BW     = CFG_DATA_WIDTH / 8;
    localparam int CORE_W = (W == 64) ? 64 : 32;

    logic                         rdy_en;
    logic                         s1_valid, s1_ecc, s1_tag;
    logic [1:0]                   s1_mode;
    logic [DW-1:0]                s1_data;
    logic [BW-1:0]                s1_be;
    logic                         s2_valid, s2_partial, s2_tag;
    logic [DW-1:0]                s2_data;
    logic [BW-1:0]                s2_be;
    logic                         armed;
    logic [CFG_INJ_CNT_WIDTH-1:0] inj_cnt;
    logic                         s1_load, s2_load, accept, tag_now;
    logic [7:0]                   core_code;
    logic [DW-1:0]                enc_word;
    logic [BW-1:0]                enc_be;
    logic                         enc_partial;

    assign s2_load     = !s2_valid || output_ready;
    assign s1_load     = !s1_valid || s2_load;
    assign input_ready = rdy_en && s1_load;
    assign accept      = input_valid && input_ready;
    // A same-cycle re-arm wins: the beat accepted with it is neither counted nor tagged.
    assign tag_now     = accept && armed && !inject_arm && (inj_cnt == '0);

    alt_mem_ddrx_ecc_encoder_core #(.W(CORE_W)) u_core (
        .data (CORE_W'(s1_data[W-1:0])),
        .code (core_code)
    );

    always_comb begin
        enc_word    = s1_data;
        enc_be      = s1_be;
        enc_partial = 1'b0;
        if (s1_ecc) begin
            enc_word    = {CFG_ECC_CODE_WIDTH'(core_code), s1_data[W-1:0]};
            enc_be      = '1;
            enc_partial = !(&s1_be[W/8-1:0]);
            if (s1_tag) begin
                case (s1_mode)
                    INJ_SBE:  enc_word[0]   = ~enc_word[0];
                    INJ_DBE:  enc_word[1:0] = ~enc_word[1:0];
                    INJ_CODE: enc_word[W]   = ~enc_word[W];
                    default:  ;
                endcase
            end
        end
    end

    always_ff @(posedge ctl_clk) begin
        if (ctl_reset) begin
            rdy_en     <= 1'b0;
            s1_valid   <= 1'b0;
            s1_ecc     <= 1'b0;
            s1_tag     <= 1'b0;
            s1_mode    <= INJ_NONE;
            s1_data    <= '0;
            s1_be      <= '0;
            s2_valid   <= 1'b0;
            s2_partial <= 1'b0;
            s2_tag     <= 1'b0;
            s2_data    <= '0;
            s2_be      <= '0;
        end else begin
            rdy_en <= 1'b1;
            if (s1_load) begin
                s1_valid <= accept;
                if (accept) begin
                    s1_data <= input_data;
                    s1_be   <= input_be;
                    s1_ecc  <= cfg_enable_ecc;
                    s1_tag  <= tag_now;
                    s1_mode <= cfg_inject_mode;
                end
            end
            if (s2_load) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data    <= enc_word;
                    s2_be      <= enc_be;
                    s2_partial <= enc_partial;
                    s2_tag     <= s1_tag;
                end
            end
        end
    end

    always_ff @(posedge ctl_clk) begin
        if (ctl_reset) begin
            armed       <= 1'b0;
            inj_cnt     <= '0;
            inject_done <= 1'b0;
        end else begin
            if (inject_arm) begin
                armed   <= 1'b1;
                inj_cnt <= cfg_inject_beat;
            end else if (accept && armed) begin
                if (inj_cnt == '0) armed <= 1'b0;
                else               inj_cnt <= inj_cnt - CFG_INJ_CNT_WIDTH'(1);
            end
            if (inject_arm)                             inject_done <= 1'b0;
            else if (s2_valid && output_ready && s2_tag) inject_done <= 1'b1;
        end
    end

    assign output_valid   = s2_valid;
    assign output_data    = s2_data;
    assign output_be      = s2_be;
    assign output_partial = s2_partial;

endmodule

// File: tb/tb_alt_mem_ddrx_ecc_encoder_pipe.sv
// Self-checking bench for the SECDED write encoder (DW=40, (39,32) code).
module tb_alt_mem_ddrx_ecc_encoder_pipe;

    logic        ctl_clk = 1'b0;
    logic        ctl_reset;
    logic        cfg_enable_ecc;
    logic [1:0]  cfg_inject_mode;
    logic [7:0]  cfg_inject_beat;
    logic        inject_arm;
    logic        inject_done;
    logic [39:0] input_data;
    logic [4:0]  input_be;
    logic        input_valid;
    logic        input_ready;
    logic [39:0] output_data;
    logic [4:0]  output_be;
    logic        output_partial;
    logic        output_valid;
    logic        output_ready;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 ctl_clk = ~ctl_clk;

    alt_mem_ddrx_ecc_encoder_pipe #(
        .CFG_DATA_WIDTH(40), .CFG_ECC_CODE_WIDTH(8), .CFG_INJ_CNT_WIDTH(8)
    ) dut (
        .ctl_clk(ctl_clk), .ctl_reset(ctl_reset), .cfg_enable_ecc(cfg_enable_ecc),
        .cfg_inject_mode(cfg_inject_mode), .cfg_inject_beat(cfg_inject_beat),
        .inject_arm(inject_arm), .inject_done(inject_done),
        .input_data(input_data), .input_be(input_be), .input_valid(input_valid),
        .input_ready(input_ready), .output_data(output_data), .output_be(output_be),
        .output_partial(output_partial), .output_valid(output_valid),
        .output_ready(output_ready)
    );

    typedef struct packed {
        logic [39:0] d;
        logic [4:0]  be;
        logic        p;
    } out_t;

    typedef struct {
        logic [39:0] d;
        logic [4:0]  be;
        logic        ecc;
        logic [39:0] xd;
        logic [4:0]  xbe;
        logic        xp;
    } vec_t;

    logic [39:0] sent_d[$];
    logic [39:0] got_d[$];
    out_t        sb[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [39:0] rand40();
        return {8'($urandom()), 32'($urandom())};
    endfunction

    function automatic bit is_pow2(input int p);
        return (p & (p - 1)) == 0;
    endfunction

    // Lay the data out in a 38-position Hamming codeword, then read the parity
    // bits off the positions; bit 6 makes the whole 39-bit word even.
    function automatic logic [7:0] ref_code(input logic [31:0] d);
        logic [38:0] cw;
        logic [7:0]  c;
        int          k;
        cw = '0;
        c  = '0;
        k  = 0;
        for (int p = 1; p <= 38; p++) begin
            if (!is_pow2(p)) begin
                cw[p] = d[k];
                k++;
            end
        end
        for (int i = 0; i < 6; i++) begin
            for (int p = 1; p <= 38; p++) begin
                if (((p >> i) & 1) == 1) c[i] = c[i] ^ cw[p];
            end
        end
        c[6] = ^d ^ ^c[5:0];
        return c;
    endfunction

    // 0 = clean, 1 = single error (corrected), 2 = double error (fatal)
    function automatic int dec_status(input logic [39:0] w);
        logic [7:0] c2;
        logic [5:0] syn;
        logic       ov;
        c2  = ref_code(w[31:0]);
        syn = w[37:32] ^ c2[5:0];
        ov  = ^w[38:0];
        if (ov) return 1;
        if (syn != 0) return 2;
        return 0;
    endfunction

    function automatic int exp_stat(input logic [1:0] mode);
        case (mode)
            2'b01:   return 1;
            2'b10:   return 2;
            2'b11:   return 1;
            default: return 0;
        endcase
    endfunction

    function automatic out_t ref_out(input logic [39:0] d, input logic [4:0] be,
                                     input logic ecc, input logic [1:0] inj);
        out_t o;
        if (!ecc) begin
            o.d  = d;
            o.be = be;
            o.p  = 1'b0;
            return o;
        end
        o.d  = {ref_code(d[31:0]), d[31:0]};
        o.be = 5'h1F;
        o.p  = (be[3:0] != 4'hF);
        case (inj)
            2'b01:   o.d[0]    = ~o.d[0];
            2'b10:   o.d[1:0]  = ~o.d[1:0];
            2'b11:   o.d[32]   = ~o.d[32];
            default: ;
        endcase
        return o;
    endfunction

    task automatic tick();
        @(posedge ctl_clk);
        #1;
    endtask

    // Back-to-back beats with output_ready held high; beat tgt is the one the
    // injection is expected to hit (-1 for none).
    task automatic run_seq(input string nm, input int n, input bit do_arm, input bit arm_with_first,
                           input logic [1:0] mode, input int beat, input int tgt,
                           input logic [7:0] ecc_pat);
        int   cyc;
        int   i;
        out_t e;
        logic ek;
        sent_d.delete();
        got_d.delete();
        cyc = 0;
        i   = 0;
        cfg_inject_mode = mode;
        cfg_inject_beat = 8'(beat);
        output_ready    = 1'b1;
        if (do_arm && !arm_with_first) begin
            inject_arm  = 1'b1;
            input_valid = 1'b0;
            tick();
            inject_arm = 1'b0;
            chk({nm, " done_clr"}, inject_done, 0);
        end
        while (got_d.size() < n && cyc < 50) begin
            input_valid    = (i < n);
            input_data     = rand40();
            input_be       = 5'h1F;
            cfg_enable_ecc = ecc_pat[i % 8];
            inject_arm     = do_arm && arm_with_first && (i == 0);
            #1;
            if (output_valid) got_d.push_back(output_data);
            if (input_valid && input_ready) begin
                sent_d.push_back(input_data);
                i++;
            end
            tick();
            cyc++;
        end
        input_valid = 1'b0;
        inject_arm  = 1'b0;
        chk({nm, " count"}, 64'(got_d.size()), 64'(n));
        for (int k = 0; k < n && k < got_d.size(); k++) begin
            ek = ecc_pat[k];
            e  = ref_out(sent_d[k], 5'h1F, ek, (k == tgt) ? mode : 2'b00);
            chk($sformatf("%s data[%0d]", nm, k), got_d[k], e.d);
            if (ek) chk($sformatf("%s dec[%0d]", nm, k), 64'(dec_status(got_d[k])),
                        64'((k == tgt) ? exp_stat(mode) : 0));
        end
        if (do_arm) chk({nm, " done"}, inject_done, (tgt >= 0 && tgt < n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got %0d expected finish", $time);
        $fatal(1);
    end

    initial begin
        vec_t        vt[7];
        int          cyc;
        int          acc;
        int          n_out;
        bit          prev_stall;
        logic [39:0] prev_d;
        out_t        e;

        vt[0] = '{40'h00_0000_0000, 5'h1F, 1'b1, 40'h00_0000_0000, 5'h1F, 1'b0};
        vt[1] = '{40'h00_FFFF_FFFF, 5'h1F, 1'b1, 40'h18_FFFF_FFFF, 5'h1F, 1'b0};
        vt[2] = '{40'hFF_FFFF_FFFF, 5'h1F, 1'b1, 40'h18_FFFF_FFFF, 5'h1F, 1'b0};
        vt[3] = '{40'hA5_1234_5678, 5'b01011, 1'b1,
                  {ref_code(32'h1234_5678), 32'h1234_5678}, 5'h1F, 1'b1};
        vt[4] = '{40'hA5_1234_5678, 5'b01011, 1'b0, 40'hA5_1234_5678, 5'b01011, 1'b0};
        vt[5] = '{40'hC3_DEAD_BEEF, 5'b10000, 1'b1,
                  {ref_code(32'hDEAD_BEEF), 32'hDEAD_BEEF}, 5'h1F, 1'b1};
        vt[6] = '{40'h00_0F0F_0F0F, 5'b01111, 1'b1,
                  {ref_code(32'h0F0F_0F0F), 32'h0F0F_0F0F}, 5'h1F, 1'b0};

        ctl_reset       = 1'b1;
        cfg_enable_ecc  = 1'b0;
        cfg_inject_mode = 2'b00;
        cfg_inject_beat = 8'd0;
        inject_arm      = 1'b0;
        input_data      = '0;
        input_be        = '0;
        input_valid     = 1'b0;
        output_ready    = 1'b0;
        tick();
        tick();
        chk("rst valid", output_valid, 0);
        chk("rst ready", input_ready, 0);
        chk("rst data", output_data, 0);
        chk("rst be", output_be, 0);
        chk("rst partial", output_partial, 0);
        chk("rst done", inject_done, 0);
        ctl_reset = 1'b0;
        #1;
        chk("ready before first edge", input_ready, 0);
        tick();
        chk("ready after reset", input_ready, 1);

        // Directed vectors; cfg_enable_ecc is flipped right after acceptance.
        foreach (vt[k]) begin
            input_valid    = 1'b1;
            input_data     = vt[k].d;
            input_be       = vt[k].be;
            cfg_enable_ecc = vt[k].ecc;
            output_ready   = 1'b1;
            #1;
            chk($sformatf("vec%0d ready", k), input_ready, 1);
            tick();
            input_valid    = 1'b0;
            cfg_enable_ecc = ~vt[k].ecc;
            chk($sformatf("vec%0d lat1 valid", k), output_valid, 0);
            tick();
            chk($sformatf("vec%0d valid", k), output_valid, 1);
            chk($sformatf("vec%0d data", k), output_data, vt[k].xd);
            chk($sformatf("vec%0d be", k), output_be, vt[k].xbe);
            chk($sformatf("vec%0d partial", k), output_partial, vt[k].xp);
            tick();
        end

        // Random stream with random backpressure against a scoreboard.
        cyc        = 0;
        acc        = 0;
        n_out      = 0;
        prev_stall = 0;
        prev_d     = '0;
        while (n_out < 100 && cyc < 3000) begin
            input_valid    = (acc < 100) && ($urandom_range(0, 3) != 0);
            input_data     = rand40();
            input_be       = 5'($urandom());
            cfg_enable_ecc = 1'($urandom());
            output_ready   = ($urandom_range(0, 2) != 0);
            #1;
            chk("rand ready", input_ready, !(sb.size() == 2 && !output_ready));
            if (prev_stall) begin
                chk("rand hold valid", output_valid, 1);
                chk("rand hold data", output_data, prev_d);
            end
            if (output_valid && output_ready) begin
                if (sb.size() == 0) begin
                    chk("rand unexpected output", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("rand data[%0d]", n_out), output_data, e.d);
                    chk($sformatf("rand be[%0d]", n_out), output_be, e.be);
                    chk($sformatf("rand partial[%0d]", n_out), output_partial, e.p);
                end
                n_out++;
            end
            if (input_valid && input_ready) begin
                sb.push_back(ref_out(input_data, input_be, cfg_enable_ecc, 2'b00));
                acc++;
            end
            prev_stall = output_valid && !output_ready;
            prev_d     = output_data;
            tick();
            cyc++;
        end
        input_valid = 1'b0;
        chk("rand outputs", 64'(n_out), 64'd100);
        chk("rand leftover", 64'(sb.size()), 64'd0);

        run_seq("inj01 b3", 6, 1, 0, 2'b01, 3, 3, 8'hFF);
        run_seq("inj10 b0", 4, 1, 0, 2'b10, 0, 0, 8'hFF);
        run_seq("inj11 b1", 3, 1, 0, 2'b11, 1, 1, 8'hFF);
        run_seq("inj00 b0", 2, 1, 0, 2'b00, 0, 0, 8'hFF);
        run_seq("inj same-cycle arm", 3, 1, 1, 2'b01, 0, 1, 8'hFF);
        run_seq("ecc toggle", 2, 0, 0, 2'b00, 0, -1, 8'h01);

        // Fill both stages, then reset mid-stream.
        output_ready   = 1'b0;
        input_valid    = 1'b1;
        input_be       = 5'h1F;
        cfg_enable_ecc = 1'b1;
        input_data     = rand40();
        tick();
        input_data = rand40();
        tick();
        input_valid = 1'b0;
        chk("full ready", input_ready, 0);
        chk("full valid", output_valid, 1);
        ctl_reset = 1'b1;
        tick();
        chk("midrst valid", output_valid, 0);
        chk("midrst ready", input_ready, 0);
        chk("midrst data", output_data, 0);
        ctl_reset    = 1'b0;
        output_ready = 1'b1;
        tick();
        chk("post-rst ready", input_ready, 1);
        acc = 0;
        for (int k = 0; k < 4; k++) begin
            if (output_valid) acc++;
            tick();
        end
        chk("post-rst no stale beats", 64'(acc), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
